frame_capture_ctrl: RTL

Parametrised SPI-to-framebuffer capture engine. It sits between the ESP32 SPI slave byte stream and a double-buffered (ping-pong) BSRAM image buffer. It assembles bytes into pixel words of configurable width and writes them into the back bank. A frame is committed only when its length is exact, and banks are swapped only at a display frame boundary, so the LCD never shows a torn or partial frame.

---
 rtl/frame_capture_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/frame_capture_ctrl.sv
// SPI byte stream to ping-pong framebuffer capture engine.
// Frames commit only on exact length; bank swap waits for display vsync.
module frame_capture_ctrl #(
    parameter int ADDR_WIDTH     = 14,
    parameter int BYTES_PER_WORD = 2,
    parameter int FRAME_WORDS    = 16384,
    parameter int BYTE_ORDER     = 0
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          cs_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic                          rx_ready,
    input  logic                          disp_vsync,
    output logic                          wr_en,
    output logic                          wr_bank,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [8*BYTES_PER_WORD-1:0]   wr_data,
    output logic                          disp_bank,
    output logic                          frame_ready,
    output logic [7:0]                    frame_count,
    output logic [1:0]                    err_flags
);
    localparam int W  = 8 * BYTES_PER_WORD;
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t              state_q, state_d;
    logic                cs_n_q;
    logic [2:0]          phase_q, phase_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        word_q, word_d, word_nxt;
    logic                bank_q, bank_d;
    logic                disp_bank_q, disp_bank_d;
    logic                frame_ready_q, frame_ready_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic [1:0]          err_q, err_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]        wr_data_q, wr_data_d;
    logic                cs_fall, cs_rise, swap;
    logic                len_ok;

    assign cs_fall = cs_n_q & ~cs_n;
    assign cs_rise = ~cs_n_q & cs_n;
    assign swap    = disp_vsync & frame_ready_q;
    assign len_ok  = (cnt_q == CW'(FRAME_WORDS)) && (phase_q == 3'd0);

    always_comb begin
        if (BYTE_ORDER == 0) word_nxt = (word_q << 8) | W'(rx_data);
        else                 word_nxt = (word_q >> 8) | (W'(rx_data) << (W - 8));
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        bank_d        = bank_q;
        disp_bank_d   = disp_bank_q;
        frame_ready_d = frame_ready_q;
        frame_count_d = frame_count_q;
        err_d         = err_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        // Swap is evaluated first so a same-cycle cs_fall sees the new front bank.
        if (swap) begin
            disp_bank_d   = ~disp_bank_q;
            frame_ready_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d       = RECV;
                    phase_d       = 3'd0;
                    cnt_d         = '0;
                    err_d         = 2'b00;
                    frame_ready_d = 1'b0;
                    bank_d        = ~disp_bank_d;
                end
            end
            RECV: begin
                if (rx_valid) begin
                    if (cnt_q < CW'(FRAME_WORDS)) begin
                        word_d = word_nxt;
                        if (phase_q == 3'(BYTES_PER_WORD - 1)) begin
                            phase_d   = 3'd0;
                            wr_en_d   = 1'b1;
                            wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                            wr_data_d = word_nxt;
                            cnt_d     = cnt_q + 1'b1;
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end else begin
                        err_d[1] = 1'b1;
                    end
                end
                if (cs_rise) state_d = CHECK;
            end
            CHECK: begin
                // An overflowed frame has full length, so it only carries bit1.
                if (len_ok && !err_q[1]) begin
                    frame_ready_d = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end else if (!len_ok) begin
                    err_d[0] = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            cs_n_q        <= 1'b1;
            phase_q       <= 3'd0;
            cnt_q         <= '0;
            word_q        <= '0;
            bank_q        <= 1'b0;
            disp_bank_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_count_q <= 8'd0;
            err_q         <= 2'b00;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cs_n_q        <= cs_n;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            bank_q        <= bank_d;
            disp_bank_q   <= disp_bank_d;
            frame_ready_q <= frame_ready_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign rx_ready    = (state_q != CHECK);
    assign wr_en       = wr_en_q;
    assign wr_bank     = bank_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign disp_bank   = disp_bank_q;
    assign frame_ready = frame_ready_q;
    assign frame_count = frame_count_q;
    assign err_flags   = err_q;
endmodule
